rah_rr_scheduler: RTL and testbench

- Weighted round-robin scheduler that shares one downstream frame-transfer resource (the RAH read/transfer path) between `TOTAL_APPS application queues.
- Each app raises a request while its data queue holds a frame. The scheduler grants one app at a time and holds the grant until the downstream signals frame completion.
- An app may keep the resource for up to its configured weight in frames before rotating; a watchdog reclaims hung grants.

---
 rtl/rah_rr_scheduler_pkg.sv | 30 +++
 rtl/rah_rr_pick.sv | 45 ++++
 rtl/rah_rr_scheduler.sv | 173 +++++++++++++++++
 tb/tb_rah_rr_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rah_rr_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rah_rr_scheduler_pkg
// Description : Shared defaults, state encoding and helpers for the RAH
//               round-robin scheduler and its rotating-priority finder.
// Revision    : 1.0 - initial release
// ============================================================================
package rah_rr_scheduler_pkg;

    // Default number of application queues sharing the transfer path
    localparam int c_total_apps     = 4;
    // Default bits per app weight (frames per turn)
    localparam int c_weight_width   = 4;
    // Default watchdog limit in cycles (0 disables the watchdog)
    localparam int c_timeout_cycles = 1024;

    // Scheduler states, explicitly encoded in two bits
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_SETTLE = 2'd2
    } sched_state_e;

    // Index width for n apps, never narrower than one bit
    function automatic int app_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage : rah_rr_scheduler_pkg
`default_nettype wire

// File: rtl/rah_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rah_rr_pick
// Description : Combinational rotating-priority finder. Returns the first
//               set request scanning ptr, ptr+1 ... N-1, 0 ... ptr-1.
// Revision    : 1.0 - initial release
// ============================================================================
module rah_rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] index
);

    logic [2*N-1:0] w_req_dbl;
    logic [N-1:0]   w_req_rot;
    logic [IDW-1:0] w_offset;
    logic [IDW:0]   w_sum;

    // Rotate the request vector so bit 0 corresponds to the pointer position
    assign w_req_dbl = {req, req};
    assign w_req_rot = N'(w_req_dbl >> ptr);

    // Lowest set bit of the rotated vector is the winner's distance from ptr
    always_comb begin
        found    = 1'b0;
        w_offset = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                found    = 1'b1;
                w_offset = IDW'(k);
            end
        end
    end

    // Translate the distance back to an absolute index, wrapping modulo N
    assign w_sum = {1'b0, ptr} + {1'b0, w_offset};
    assign index = (w_sum >= (IDW + 1)'(N)) ? IDW'(w_sum - (IDW + 1)'(N))
                                             : w_sum[IDW-1:0];

endmodule : rah_rr_pick
`default_nettype wire

// File: rtl/rah_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rah_rr_scheduler
// Description : Weighted round-robin scheduler granting the RAH frame
//               transfer path to one application queue at a time, with a
//               per-app frame credit and a watchdog for hung grants.
// Revision    : 1.0 - initial release
// ============================================================================
module rah_rr_scheduler
    import rah_rr_scheduler_pkg::*;
#(
    parameter int TOTAL_APPS     = c_total_apps,
    parameter int APP_ID_WIDTH   = app_id_width(TOTAL_APPS),
    parameter int WEIGHT_WIDTH   = c_weight_width,
    parameter int TIMEOUT_CYCLES = c_timeout_cycles
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable,
    input  logic [TOTAL_APPS-1:0]              app_req,
    input  logic [TOTAL_APPS*WEIGHT_WIDTH-1:0] app_weight,
    input  logic                               frame_done,
    output logic                               sel_valid,
    output logic                               sel_start,
    output logic [APP_ID_WIDTH-1:0]            sel_app_id,
    output logic [TOTAL_APPS-1:0]              sel_onehot,
    output logic                               timeout,
    output logic                               err_spurious_done
);

    localparam int c_timer_w = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [c_timer_w-1:0] c_timer_last =
        c_timer_w'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [APP_ID_WIDTH-1:0] c_last_app = APP_ID_WIDTH'(TOTAL_APPS - 1);
    localparam bit c_wdog_en = (TIMEOUT_CYCLES > 0);

    sched_state_e             r_state;
    logic [APP_ID_WIDTH-1:0]  r_ptr;
    logic [APP_ID_WIDTH-1:0]  r_cur;
    logic [WEIGHT_WIDTH-1:0]  r_credit;
    logic [c_timer_w-1:0]     r_timer;
    logic                     r_sel_valid;
    logic                     r_sel_start;
    logic [TOTAL_APPS-1:0]    r_sel_onehot;
    logic                     r_err;

    logic [WEIGHT_WIDTH-1:0]  w_weight [TOTAL_APPS];
    logic [APP_ID_WIDTH-1:0]  w_ptr_rot;
    logic [APP_ID_WIDTH-1:0]  w_pick_ptr;
    logic                     w_found;
    logic [APP_ID_WIDTH-1:0]  w_win;
    logic [WEIGHT_WIDTH-1:0]  w_load_credit;
    logic                     w_timer_hit;
    logic                     w_regrant;

    // Unpack the flat weight bus into one entry per app
    generate
        for (genvar gi = 0; gi < TOTAL_APPS; gi++) begin : g_weight
            assign w_weight[gi] = app_weight[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        end
    endgenerate

    // When a turn ends in SETTLE the search starts just past the current app,
    // so the rotated pointer is used for arbitration in that same cycle
    assign w_ptr_rot  = (r_cur == c_last_app) ? '0 : r_cur + 1'b1;
    assign w_pick_ptr = (r_state == ST_SETTLE) ? w_ptr_rot : r_ptr;

    rah_rr_pick #(
        .N   (TOTAL_APPS),
        .IDW (APP_ID_WIDTH)
    ) u_pick (
        .req   (app_req),
        .ptr   (w_pick_ptr),
        .found (w_found),
        .index (w_win)
    );

    // A zero weight still earns one frame per turn
    assign w_load_credit = (w_weight[w_win] == '0) ? WEIGHT_WIDTH'(1) : w_weight[w_win];
    assign w_timer_hit   = c_wdog_en && (r_timer == c_timer_last);
    assign w_regrant     = enable && (r_credit != '0) && app_req[r_cur];

    // Scheduler state machine with registered grant outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_cur        <= '0;
            r_credit     <= '0;
            r_timer      <= '0;
            r_sel_valid  <= 1'b0;
            r_sel_start  <= 1'b0;
            r_sel_onehot <= '0;
        end else begin
            r_sel_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable && w_found) begin
                        r_state      <= ST_ACTIVE;
                        r_cur        <= w_win;
                        r_credit     <= w_load_credit;
                        r_timer      <= '0;
                        r_sel_valid  <= 1'b1;
                        r_sel_start  <= 1'b1;
                        r_sel_onehot <= TOTAL_APPS'(1) << w_win;
                    end
                end
                ST_ACTIVE: begin
                    r_timer <= r_timer + 1'b1;
                    if (frame_done) begin
                        r_credit     <= (r_credit != '0) ? r_credit - 1'b1 : '0;
                        r_state      <= ST_SETTLE;
                        r_sel_valid  <= 1'b0;
                        r_sel_onehot <= '0;
                    end else if (w_timer_hit) begin
                        r_credit     <= '0;
                        r_state      <= ST_SETTLE;
                        r_sel_valid  <= 1'b0;
                        r_sel_onehot <= '0;
                    end
                end
                ST_SETTLE: begin
                    r_timer <= '0;
                    if (w_regrant) begin
                        r_state      <= ST_ACTIVE;
                        r_sel_valid  <= 1'b1;
                        r_sel_start  <= 1'b1;
                        r_sel_onehot <= TOTAL_APPS'(1) << r_cur;
                    end else begin
                        r_ptr    <= w_ptr_rot;
                        r_credit <= '0;
                        if (enable && w_found) begin
                            r_state      <= ST_ACTIVE;
                            r_cur        <= w_win;
                            r_credit     <= w_load_credit;
                            r_sel_valid  <= 1'b1;
                            r_sel_start  <= 1'b1;
                            r_sel_onehot <= TOTAL_APPS'(1) << w_win;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_sel_valid  <= 1'b0;
                    r_sel_onehot <= '0;
                end
            endcase
        end
    end

    // Sticky flag for completions that arrive with no grant outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (frame_done && (r_state != ST_ACTIVE)) begin
            r_err <= 1'b1;
        end
    end

    // The watchdog pulse is decoded on the last allowed ACTIVE cycle so it
    // lines up with the grant it aborts; a same-cycle completion suppresses it
    assign timeout = (r_state == ST_ACTIVE) && w_timer_hit && !frame_done;

    assign sel_valid         = r_sel_valid;
    assign sel_start         = r_sel_start;
    assign sel_app_id        = r_cur;
    assign sel_onehot        = r_sel_onehot;
    assign err_spurious_done = r_err;

endmodule : rah_rr_scheduler
`default_nettype wire

// File: tb/tb_rah_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rah_rr_scheduler
// Description : Directed scoreboard bench for rah_rr_scheduler. Stimulus
//               pushes the expected granted app ids; a monitor pops them on
//               every sel_start.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rah_rr_scheduler;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int WW  = 4;
    localparam int TO  = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic [N-1:0]   app_req = '0;
    logic [N*WW-1:0] app_weight = '0;
    logic           fd_auto = 1'b0;
    logic           fd_man = 1'b0;
    logic           auto_done = 1'b0;
    logic           frame_done;
    logic           sel_valid;
    logic           sel_start;
    logic [IDW-1:0] sel_app_id;
    logic [N-1:0]   sel_onehot;
    logic           timeout;
    logic           err_spurious_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_q[$];
    int start_times[$];

    assign frame_done = fd_auto | fd_man;

    rah_rr_scheduler #(
        .TOTAL_APPS     (N),
        .APP_ID_WIDTH   (IDW),
        .WEIGHT_WIDTH   (WW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable            (enable),
        .app_req           (app_req),
        .app_weight        (app_weight),
        .frame_done        (frame_done),
        .sel_valid         (sel_valid),
        .sel_start         (sel_start),
        .sel_app_id        (sel_app_id),
        .sel_onehot        (sel_onehot),
        .timeout           (timeout),
        .err_spurious_done (err_spurious_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: every grant start must match the next expected app
    always @(negedge clk) begin
        int e;
        cyc = cyc + 1;
        if (rst_n && sel_start) begin
            start_times.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_grant: got app %0d, required no grant (t=%0t)", sel_app_id, $time);
            end else begin
                e = exp_q.pop_front();
                check("grant_id", int'(sel_app_id), e);
                check("grant_onehot", int'(sel_onehot), 1 << e);
                check("grant_valid", int'(sel_valid), 1);
            end
        end
    end

    // Downstream model: completes each frame 3 cycles after its sel_start
    initial begin
        forever begin
            @(negedge clk);
            if (auto_done && sel_start) begin
                repeat (3) @(posedge clk);
                #1 fd_auto = 1'b1;
                @(posedge clk);
                #1 fd_auto = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        fd_man = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_start(input string name, input int max_cycles);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (sel_start) seen = 1'b1;
        end
        if (!seen) check({name, "_start_timeout"}, 0, 1);
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clk);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic quiesce(input string name, input int n);
        enable = 1'b0;
        repeat (n) @(negedge clk);
        check({name, "_leftover"}, exp_q.size(), 0);
        check({name, "_idle_valid"}, int'(sel_valid), 0);
    endtask

    // Global bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: got still running, required finished");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        // Reset state
        #1;
        check("rst_valid", int'(sel_valid), 0);
        check("rst_start", int'(sel_start), 0);
        check("rst_id", int'(sel_app_id), 0);
        check("rst_onehot", int'(sel_onehot), 0);
        check("rst_timeout", int'(timeout), 0);
        check("rst_err", int'(err_spurious_done), 0);
        do_reset();

        // Equal weights, everyone requesting: plain rotation, 5-cycle spacing
        start_times.delete();
        app_weight = {4'd1, 4'd1, 4'd1, 4'd1};
        app_req    = 4'b1111;
        auto_done  = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        exp_q.push_back(3); exp_q.push_back(0);
        enable = 1'b1;
        wait_drain("t1", 100);
        enable = 1'b0;
        check("t1_nstarts", start_times.size(), 5);
        for (int i = 1; i < start_times.size(); i++)
            check("t1_spacing", start_times[i] - start_times[i-1], 5);
        quiesce("t1", 12);
        do_reset();

        // Weighted: app0 w=1, app2 w=3, only apps 0 and 2 requesting
        app_weight = {4'd0, 4'd3, 4'd1, 4'd1};
        app_req    = 4'b0101;
        foreach (exp_q[i]) ;
        exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(2);
        exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(2); exp_q.push_back(2);
        enable = 1'b1;
        wait_drain("t2", 150);
        enable = 1'b0;
        quiesce("t2", 12);
        do_reset();

        // Watchdog: app1 never completes, pulse on 8th ACTIVE cycle, then app2
        auto_done  = 1'b0;
        app_weight = {4'd1, 4'd1, 4'd1, 4'd1};
        app_req    = 4'b0110;
        exp_q.push_back(1); exp_q.push_back(2);
        enable = 1'b1;
        wait_start("t3_first", 10);
        for (int k = 1; k <= TO; k++) begin
            if (k > 1) @(negedge clk);
            check("t3_timeout_pulse", int'(timeout), (k == TO) ? 1 : 0);
            if (k == TO) check("t3_valid_at_timeout", int'(sel_valid), 1);
        end
        @(negedge clk);
        check("t3_valid_after", int'(sel_valid), 0);
        check("t3_timeout_cleared", int'(timeout), 0);
        wait_start("t3_second", 6);
        enable = 1'b0;
        quiesce("t3", 16);
        check("t3_no_err", int'(err_spurious_done), 0);
        do_reset();

        // Spurious completion while idle
        app_req = 4'b0000;
        enable  = 1'b1;
        @(negedge clk);
        check("t4_err_before", int'(err_spurious_done), 0);
        fd_man = 1'b1;
        @(negedge clk);
        fd_man = 1'b0;
        check("t4_err_set", int'(err_spurious_done), 1);
        repeat (5) @(negedge clk);
        check("t4_err_sticky", int'(err_spurious_done), 1);
        check("t4_no_grant", int'(sel_valid), 0);
        enable = 1'b0;
        do_reset();

        // Enable dropped mid-grant on app3 (w=2): hold, no re-grant, wrap to 0
        start_times.delete();
        app_weight = {4'd2, 4'd1, 4'd1, 4'd1};
        app_req    = 4'b1000;
        exp_q.push_back(3);
        enable = 1'b1;
        wait_start("t5_first", 10);
        enable = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_valid_held", int'(sel_valid), 1);
        fd_man = 1'b1;
        @(negedge clk);
        fd_man = 1'b0;
        check("t5_valid_drop", int'(sel_valid), 0);
        repeat (6) @(negedge clk);
        check("t5_no_regrant", int'(sel_valid), 0);
        check("t5_nstarts", start_times.size(), 1);
        app_req = 4'b1001;
        exp_q.push_back(0);
        enable = 1'b1;
        wait_start("t5_resume", 6);
        enable = 1'b0;
        quiesce("t5", 16);
        do_reset();

        // Asynchronous reset in the middle of a grant
        app_req = 4'b0100;
        exp_q.push_back(2);
        enable = 1'b1;
        wait_start("t6_first", 10);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("t6_async_valid", int'(sel_valid), 0);
        check("t6_async_start", int'(sel_start), 0);
        check("t6_async_id", int'(sel_app_id), 0);
        check("t6_async_onehot", int'(sel_onehot), 0);
        check("t6_async_timeout", int'(timeout), 0);
        app_req = 4'b0110;
        exp_q.push_back(1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_start("t6_after", 6);
        enable = 1'b0;
        quiesce("t6", 16);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rah_rr_scheduler
`default_nettype wire
